// File: rtl/bb_uart_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : bb_uart_frame_rx_if
//  Purpose  : Request handshake bundle between the bus-bridge UART frame
//             receiver (master) and the slave-side bus master logic (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface bb_uart_frame_rx_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/bb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : bb_uart_frame_rx
//  Purpose  : 8N1 UART receiver that assembles bus-bridge request frames
//             (header, addr_h, addr_l[, data]) into one valid/ready request.
//  Revision : 1.0  initial release
// ============================================================================
module bb_uart_frame_rx #(
    parameter int ADDR_WIDTH            = 16,
    parameter int DATA_WIDTH            = 8,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int TIMEOUT_CLKS          = 16 * UART_CLOCKS_PER_PULSE
) (
    input  wire logic                clk,
    input  wire logic                btn_reset,
    input  wire logic                uart_rx,
    bb_uart_frame_rx_if.master       req,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy
);

    // Start-bit check point; never zero so a tiny CPP still works.
    localparam int c_half  = (UART_CLOCKS_PER_PULSE / 2 > 0) ? UART_CLOCKS_PER_PULSE / 2 : 1;
    localparam int c_cnt_w = $clog2(UART_CLOCKS_PER_PULSE + 1);
    localparam int c_to_w  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_cnt_w-1:0] c_cpp_last  = c_cnt_w'(UART_CLOCKS_PER_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
    localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        BE_IDLE  = 2'd0,
        BE_START = 2'd1,
        BE_DATA  = 2'd2,
        BE_STOP  = 2'd3
    } be_state_t;

    typedef enum logic [1:0] {
        FA_HDR    = 2'd0,
        FA_ADDR_H = 2'd1,
        FA_ADDR_L = 2'd2,
        FA_DATA   = 2'd3
    } fa_state_t;

    logic r_rx_meta, r_rx_sync, r_rx_prev;

    be_state_t r_be_state, w_be_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic w_cnt_clr, w_shift, w_byte_stb, w_stop_err;

    fa_state_t r_fa_state, w_fa_next;
    logic       r_is_write;
    logic [7:0] r_addr_h, r_addr_l;
    logic       w_complete, w_hdr_ovr, w_accept, w_load, w_drop, w_err, w_busy;
    logic [7:0] w_addr_l;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic [c_to_w-1:0] r_to_cnt;
    logic w_to_run, w_timeout;

    logic                  r_req_valid, r_req_write;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Bit engine state register.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) r_be_state <= BE_IDLE;
        else           r_be_state <= w_be_next;
    end

    // Bit engine next state and per-cycle control strobes.
    always_comb begin
        w_be_next  = r_be_state;
        w_cnt_clr  = 1'b0;
        w_shift    = 1'b0;
        w_byte_stb = 1'b0;
        w_stop_err = 1'b0;
        case (r_be_state)
            BE_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_be_next = BE_START;
                    w_cnt_clr = 1'b1;
                end
            end
            BE_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_clr = 1'b1;
                    w_be_next = r_rx_sync ? BE_IDLE : BE_DATA;
                end
            end
            BE_DATA: begin
                if (r_cnt == c_cpp_last) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) w_be_next = BE_STOP;
                end
            end
            BE_STOP: begin
                if (r_cnt == c_cpp_last) begin
                    w_cnt_clr = 1'b1;
                    w_be_next = BE_IDLE;
                    if (r_rx_sync) w_byte_stb = 1'b1;
                    else           w_stop_err = 1'b1;
                end
            end
            default: w_be_next = BE_IDLE;
        endcase
    end

    // Bit timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            if (w_cnt_clr)                 r_cnt <= '0;
            else if (r_be_state != BE_IDLE) r_cnt <= r_cnt + 1'b1;
            if (r_be_state == BE_START)    r_bit_idx <= 3'd0;
            else if (w_shift)              r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift)                   r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    assign w_busy    = (r_fa_state != FA_HDR);
    assign w_to_run  = w_busy && (r_be_state == BE_IDLE);
    assign w_timeout = w_to_run && (r_to_cnt == c_to_last);
    assign w_err     = w_stop_err | w_timeout;

    // Inter-byte timeout: counts idle line time inside a partial frame.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset)                      r_to_cnt <= '0;
        else if (w_byte_stb || w_timeout)   r_to_cnt <= '0;
        else if (w_to_run)                  r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Frame assembler state register.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) r_fa_state <= FA_HDR;
        else           r_fa_state <= w_fa_next;
    end

    // Frame assembler next state; errors always abandon the current frame.
    always_comb begin
        w_fa_next  = r_fa_state;
        w_complete = 1'b0;
        w_hdr_ovr  = 1'b0;
        if (w_err) begin
            w_fa_next = FA_HDR;
        end else if (w_byte_stb) begin
            case (r_fa_state)
                FA_HDR: begin
                    if (r_req_valid)                    w_hdr_ovr = 1'b1;
                    else if (r_shift[7:1] == 7'b1010101) w_fa_next = FA_ADDR_H;
                end
                FA_ADDR_H: w_fa_next = FA_ADDR_L;
                FA_ADDR_L: begin
                    if (r_is_write) begin
                        w_fa_next = FA_DATA;
                    end else begin
                        w_complete = 1'b1;
                        w_fa_next  = FA_HDR;
                    end
                end
                FA_DATA: begin
                    w_complete = 1'b1;
                    w_fa_next  = FA_HDR;
                end
                default: w_fa_next = FA_HDR;
            endcase
        end
    end

    // A read completes on the low address byte itself, so take it from the shifter.
    assign w_addr_l = (r_fa_state == FA_ADDR_L) ? r_shift : r_addr_l;
    assign w_addr   = ADDR_WIDTH'({r_addr_h, w_addr_l});
    assign w_accept = r_req_valid & req.req_ready;
    assign w_load   = w_complete & (~r_req_valid | w_accept);
    assign w_drop   = w_complete & r_req_valid & ~w_accept;

    // Header type and address byte capture.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_is_write <= 1'b0;
            r_addr_h   <= 8'd0;
            r_addr_l   <= 8'd0;
        end else if (w_byte_stb) begin
            if (r_fa_state == FA_HDR && w_fa_next == FA_ADDR_H) r_is_write <= r_shift[0];
            if (r_fa_state == FA_ADDR_H) r_addr_h <= r_shift;
            if (r_fa_state == FA_ADDR_L) r_addr_l <= r_shift;
        end
    end

    // Request holding registers and error/overrun pulses.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_load) begin
                r_req_valid <= 1'b1;
                r_req_write <= r_is_write;
                r_req_addr  <= w_addr;
                r_req_wdata <= r_is_write ? DATA_WIDTH'(r_shift) : '0;
            end else if (w_accept) begin
                r_req_valid <= 1'b0;
            end
            frame_err <= w_err;
            overrun   <= w_hdr_ovr | w_drop;
        end
    end

    assign req.req_valid = r_req_valid;
    assign req.req_write = r_req_write;
    assign req.req_addr  = r_req_addr;
    assign req.req_wdata = r_req_wdata;
    assign busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bb_uart_frame_rx
//  Purpose  : Scoreboard bench for bb_uart_frame_rx with a byte-level
//             frame model and randomized frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bb_uart_frame_rx;

    localparam int CPP = 16;
    localparam int TO  = 64;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } req_t;

    logic clk = 1'b0;
    logic btn_reset, uart_rx, frame_err, overrun, busy;

    bb_uart_frame_rx_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    bb_uart_frame_rx #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8),
        .UART_CLOCKS_PER_PULSE(CPP), .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .btn_reset(btn_reset), .uart_rx(uart_rx),
        .req(bus), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int exp_err = 0, exp_ovr = 0;
    int err_seen = 0, ovr_seen = 0, valid_cycles = 0;
    req_t exp_q[$];
    req_t mon_e;

    // Byte-level reference model of the frame protocol.
    int         m_pos  = 0;
    bit         m_pend = 0;
    logic       m_wr;
    logic [7:0] m_ah, m_al;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_finish(input logic [7:0] d);
        req_t r;
        m_pos = 0;
        if (m_pend) begin
            exp_ovr++;
        end else begin
            r.w = m_wr;
            r.a = {m_ah, m_al};
            r.d = m_wr ? d : 8'h00;
            exp_q.push_back(r);
            m_pend = !bus.req_ready;
        end
    endtask

    task automatic mdl_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err++;
            m_pos = 0;
            return;
        end
        case (m_pos)
            0: begin
                if (m_pend) exp_ovr++;
                else if (b == 8'hAA || b == 8'hAB) begin
                    m_wr  = b[0];
                    m_pos = 1;
                end
            end
            1: begin m_ah = b; m_pos = 2; end
            2: begin
                m_al = b;
                if (m_wr) m_pos = 3;
                else      m_finish(8'h00);
            end
            default: m_finish(b);
        endcase
    endtask

    task automatic mdl_timeout();
        if (m_pos != 0) begin
            exp_err++;
            m_pos = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
        uart_rx = 1'b0;
        repeat (CPP) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPP) tick();
        end
        mdl_byte(b, ok);
        uart_rx = ok;
        repeat (CPP) tick();
        uart_rx = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic settle();
        repeat (100) tick();
        mdl_timeout();
        chk("err_count", err_seen, exp_err);
        chk("ovr_count", ovr_seen, exp_ovr);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: counts pulses and pops the scoreboard on every accepted request.
    always @(negedge clk) begin
        if (!btn_reset) begin
            if (frame_err)     err_seen++;
            if (overrun)       ovr_seen++;
            if (bus.req_valid) valid_cycles++;
            if (bus.req_valid && bus.req_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr 0x%0h, none expected", bus.req_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("req_write", {31'd0, bus.req_write}, {31'd0, mon_e.w});
                    chk("req_addr",  {16'd0, bus.req_addr},  {16'd0, mon_e.a});
                    chk("req_wdata", {24'd0, bus.req_wdata}, {24'd0, mon_e.d});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        logic [7:0] hdr;
        btn_reset = 1'b1;
        uart_rx   = 1'b1;
        bus.req_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", bus.req_valid, 0);
        chk("rst_ferr",  frame_err, 0);
        chk("rst_ovr",   overrun, 0);
        chk("rst_busy",  busy, 0);
        btn_reset = 1'b0;
        repeat (5) tick();

        // Read frame, consumer always ready: exactly one valid cycle.
        vc0 = valid_cycles;
        send_byte(8'hAA, 1, 4);
        send_byte(8'h12, 1, 4);
        chk("busy_mid_frame", busy, 1);
        send_byte(8'h34, 1, 4);
        settle();
        chk("one_valid_cycle", valid_cycles - vc0, 1);

        // Write frame held by back-pressure, then accepted.
        bus.req_ready = 1'b0;
        send_byte(8'hAB, 1, 4);
        send_byte(8'h00, 1, 4);
        send_byte(8'h05, 1, 4);
        send_byte(8'h5A, 1, 4);
        repeat (100) tick();
        chk("held_valid", bus.req_valid, 1);
        chk("held_write", bus.req_write, 1);
        chk("held_addr",  bus.req_addr, 16'h0005);
        chk("held_wdata", bus.req_wdata, 8'h5A);
        bus.req_ready = 1'b1;
        m_pend = 0;
        tick();
        chk("valid_drop", bus.req_valid, 0);
        settle();

        // Bad stop bit on ADDR_H, then a clean read frame.
        send_byte(8'hAA, 1, 4);
        send_byte(8'h77, 0, 6);
        send_byte(8'hAA, 1, 4);
        send_byte(8'h00, 1, 4);
        send_byte(8'h01, 1, 4);
        settle();

        // Non-header byte is ignored silently.
        send_byte(8'h55, 1, 4);
        send_byte(8'hAA, 1, 4);
        send_byte(8'hFF, 1, 4);
        send_byte(8'hFF, 1, 4);
        settle();

        // Inter-byte timeout in the middle of a write frame.
        send_byte(8'hAB, 1, 4);
        send_byte(8'h00, 1, 0);
        repeat (40) tick();
        chk("no_early_timeout", err_seen, exp_err);
        repeat (160) tick();
        mdl_timeout();
        chk("timeout_err", err_seen, exp_err);
        chk("timeout_not_busy", busy, 0);
        send_byte(8'hAA, 1, 4);
        send_byte(8'h00, 1, 4);
        send_byte(8'h02, 1, 4);
        settle();

        // Randomized frames with occasional bad stop bits.
        for (int f = 0; f < 8; f++) begin
            case ($urandom_range(0, 3))
                0:       hdr = 8'hAA;
                1, 2:    hdr = 8'hAB;
                default: hdr = 8'($urandom);
            endcase
            send_byte(hdr, ($urandom_range(0, 9) != 0), $urandom_range(4, 30));
            for (int k = 0; k < 3; k++)
                send_byte(8'($urandom), ($urandom_range(0, 9) != 0), $urandom_range(4, 30));
        end
        settle();

        // Two frames under back-pressure, a start glitch, then reset mid-byte.
        bus.req_ready = 1'b0;
        send_byte(8'hAA, 1, 4);
        send_byte(8'h0A, 1, 4);
        send_byte(8'hBC, 1, 4);
        send_byte(8'hAB, 1, 4);
        send_byte(8'h01, 1, 4);
        send_byte(8'h02, 1, 4);
        send_byte(8'h03, 1, 4);
        repeat (10) tick();
        chk("pend_ovr", ovr_seen, exp_ovr);
        chk("pend_addr", bus.req_addr, 16'h0ABC);
        chk("pend_write", bus.req_write, 0);
        uart_rx = 1'b0;
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (40) tick();
        chk("glitch_ovr", ovr_seen, exp_ovr);
        chk("glitch_valid", bus.req_valid, 1);
        uart_rx = 1'b0;
        repeat (CPP * 3) tick();
        btn_reset = 1'b1;
        #1;
        chk("async_rst_valid", bus.req_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ferr", frame_err, 0);
        uart_rx = 1'b1;
        exp_q.delete();
        m_pos  = 0;
        m_pend = 0;
        repeat (5) tick();
        btn_reset = 1'b0;
        bus.req_ready = 1'b1;
        repeat (5) tick();
        send_byte(8'hAB, 1, 4);
        send_byte(8'h12, 1, 4);
        send_byte(8'h34, 1, 4);
        send_byte(8'h56, 1, 4);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
